imem_dmem_arbiter: RTL and testbench
====================================

// Module: imem_dmem_arbiter
// PURPOSE
//  Shares one unified single-port memory between the fetch stage (read-only) and the
//  load/store stage. Sequences req/gnt/rvalid transactions and returns read data to the
//  winner. Drives the fetch and data stall lines consumed by the hazard unit.
//  Drops stale fetch responses after a flush. Round-robin on contention.
// PARAMETERS
//  XLEN      32    address/data width (matches `XLEN)
//  MAX_WAIT  255   cycles an issued access may stay outstanding before bus_err
// PORTS
//  clk        in   1     clock
//  rst        in   1     synchronous, active-high reset
//  if_req     in   1     fetch wants word at if_addr
//  if_addr    in   XLEN  fetch address (pc_imem)
//  if_flush   in   1     fetch redirected; any outstanding fetch is stale
//  if_rdata   out  XLEN  instruction word (instr_imem); valid when if_req & !if_stall
//  if_stall   out  1     fetch must hold pc
//  d_req      in   1     load/store request
//  d_we       in   1     1=store, 0=load
//  d_be       in   4     byte enables (stores)
//  d_addr     in   XLEN  data address
//  d_wdata    in   XLEN  store data
//  d_rdata    out  XLEN  load data; valid when d_req & !d_stall
//  d_stall    out  1     memory stage must hold
//  mem_req    out  1     request to memory; held until mem_gnt
//  mem_we     out  1     write enable
//  mem_be     out  4     byte enables
//  mem_addr   out  XLEN  address
//  mem_wdata  out  XLEN  write data
//  mem_gnt    in   1     memory accepted request this cycle
//  mem_rvalid in   1     response (read data or write ack); never in the same cycle as gnt
//  mem_rdata  in   XLEN  read data
//  bus_err    out  1     sticky: access exceeded MAX_WAIT
// BEHAVIOUR
//  - Reset: state IDLE, mem_req/mem_we/mem_be/mem_addr/mem_wdata=0, drop=0, wait_cnt=0,
//    bus_err=0, rr_last=DATA (fetch wins first tie).
//  - States: IDLE, F_REQ, F_WAIT, D_REQ, D_WAIT.
//  - IDLE: only if_req -> F_REQ; only d_req -> D_REQ; both -> side not in rr_last.
//    Transition latches addr/we/be/wdata into mem_* regs; fetch forces we=0, be=0.
//    rr_last updates to the chosen side.
//  - *_REQ: mem_req=1, mem_* stable until mem_gnt; then -> *_WAIT, mem_req=0.
//  - *_WAIT: on mem_rvalid -> IDLE. One transaction in flight max; no pipelining.
//  - Stalls are combinational:
//    if_stall = if_req & !(F_WAIT & mem_rvalid & !drop);
//    d_stall = d_req & !(D_WAIT & mem_rvalid).
//  - if_rdata = d_rdata = mem_rdata (pass-through, zero added latency).
//  - Min latency, request to release: 3 cycles
//    (IDLE capture, REQ with gnt, WAIT with rvalid); next request is seen in IDLE.
//  - Flush: if_flush in F_REQ or F_WAIT sets drop. The request is not withdrawn.
//    The response is discarded (if_stall stays 1), drop clears, -> IDLE, refetch at new if_addr.
//    if_flush in IDLE, D_* or on the discard cycle itself: no effect.
//  - if_addr change while fetch is outstanding without if_flush: ignored (latched address used).
//  - d_req deassert mid-transaction: access still completes; response ignored.
//  - wait_cnt: clears on IDLE->*_REQ, increments each *_REQ/*_WAIT cycle, saturates.
//    Reaching MAX_WAIT sets bus_err (sticky to rst). State is unchanged.
//  - mem_rvalid in IDLE or *_REQ: ignored (stray).
//  - rst mid-transaction: -> IDLE next edge; outputs to reset values.
//    A late rvalid after reset is ignored per the stray rule.
// STRUCTURE
//  - mem_arb_pkg: arb_state_e enum (5 states), arb_side_e {SIDE_FETCH, SIDE_DATA};
//    widths from constants.vh.
//  - Sub-module arb_wait_timer: saturating counter with clear/enable/limit -> expired.
//  - FSM, request mux and stall logic in this module.
// TESTING
//  1) rst; if_req=1, if_addr=0x0; gnt at cycle 1, rvalid at cycle 2 with rdata=0x00000013
//     -> if_stall=0 only in cycle 2, if_rdata=0x13, mem_addr=0x0, mem_we=0.
//  2) if_req and d_req (store 0x10, be=0xF, wdata=0xDEADBEEF) both raised from reset
//     -> fetch issued first, then store with mem_we=1, mem_wdata=0xDEADBEEF;
//     repeat tie -> fetch again.
//  3) Fetch 0x40 outstanding; if_flush in F_WAIT; rvalid rdata=0xBAD
//     -> if_stall stays 1, data dropped; next issue has mem_addr = new if_addr 0x80.
//  4) Memory holds gnt low 3 cycles -> mem_req and mem_addr stable all 4 cycles,
//     d_stall=1 throughout.
//  5) MAX_WAIT=8, never give rvalid -> bus_err rises after 8 outstanding cycles and
//     stays set; rst clears it and returns IDLE.
//  6) rst asserted in D_WAIT, then rvalid -> ignored, mem_req=0, no stall release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ARB_XLEN     = 32;
    localparam int unsigned ARB_BE_W     = 4;
    localparam int unsigned ARB_MAX_WAIT = 255;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_F_REQ  = 3'd1,
        ST_F_WAIT = 3'd2,
        ST_D_REQ  = 3'd3,
        ST_D_WAIT = 3'd4
    } arb_state_e;

    typedef enum logic {
        SIDE_FETCH = 1'b0,
        SIDE_DATA  = 1'b1
    } arb_side_e;

    // Round-robin choice: on a tie the side that did not win last time goes next.
    function automatic arb_side_e pick_side(input logic if_req, input logic d_req,
                                            input arb_side_e rr_last);
        if (if_req && d_req) begin
            return (rr_last == SIDE_DATA) ? SIDE_FETCH : SIDE_DATA;
        end
        if (d_req) begin
            return SIDE_DATA;
        end
        return SIDE_FETCH;
    endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// Saturating outstanding-cycle counter; flags when the next count reaches LIMIT.
module arb_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_W'(LIMIT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Looks at the next count so the error flop sets on the edge the limit is reached.
    assign expired_c = en && (cnt_d == CNT_W'(LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates fetch and load/store access to one single-port memory, one
// transaction in flight, with stale-fetch dropping and a sticky timeout flag.
module imem_dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned XLEN     = ARB_XLEN,
    parameter int unsigned MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [XLEN-1:0]     if_addr,
    input  logic                if_flush,
    output logic [XLEN-1:0]     if_rdata,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ARB_BE_W-1:0] d_be,
    input  logic [XLEN-1:0]     d_addr,
    input  logic [XLEN-1:0]     d_wdata,
    output logic [XLEN-1:0]     d_rdata,
    output logic                d_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ARB_BE_W-1:0] mem_be,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                bus_err
);

    arb_state_e          state_q,     state_d;
    arb_side_e           rr_last_q,   rr_last_d;
    arb_side_e           pick;
    logic                drop_q,      drop_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ARB_BE_W-1:0] mem_be_q,    mem_be_d;
    logic [XLEN-1:0]     mem_addr_q,  mem_addr_d;
    logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
    logic                bus_err_q,   bus_err_d;
    logic                timer_clr;
    logic                timer_en;
    logic                timer_expired;

    arb_wait_timer #(
        .LIMIT(MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (timer_clr),
        .en        (timer_en),
        .expired_c (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        drop_d      = drop_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        timer_clr   = 1'b0;
        timer_en    = 1'b0;
        pick        = pick_side(if_req, d_req, rr_last_q);

        unique case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (if_req || d_req) begin
                    timer_clr = 1'b1;
                    mem_req_d = 1'b1;
                    rr_last_d = pick;
                    if (pick == SIDE_FETCH) begin
                        state_d     = ST_F_REQ;
                        mem_we_d    = 1'b0;
                        mem_be_d    = '0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end else begin
                        state_d     = ST_D_REQ;
                        mem_we_d    = d_we;
                        mem_be_d    = d_be;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end
                end
            end
            ST_F_REQ: begin
                timer_en = 1'b1;
                drop_d   = drop_q | if_flush;
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_F_WAIT;
                end
            end
            ST_D_REQ: begin
                timer_en = 1'b1;
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_D_WAIT;
                end
            end
            ST_F_WAIT: begin
                timer_en = 1'b1;
                // A flush on the response cycle itself does not affect the next fetch.
                if (mem_rvalid) begin
                    drop_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    drop_d = drop_q | if_flush;
                end
            end
            ST_D_WAIT: begin
                timer_en = 1'b1;
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus_err_d = bus_err_q | timer_expired;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_last_q   <= SIDE_DATA;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            drop_q      <= drop_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Stall release is combinational so the response is consumed in the rvalid cycle.
    assign if_stall  = if_req & ~((state_q == ST_F_WAIT) & mem_rvalid & ~drop_q);
    assign d_stall   = d_req  & ~((state_q == ST_D_WAIT) & mem_rvalid);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scripted cycle-by-cycle bench for imem_dmem_arbiter with issue and read-data scoreboards.
module tb_imem_dmem_arbiter;

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic            we;
        logic [3:0]      be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } cmd_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            if_req, if_flush, if_stall;
    logic [XLEN-1:0] if_addr, if_rdata;
    logic            d_req, d_we, d_stall;
    logic [3:0]      d_be;
    logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
    logic            mem_req, mem_we, mem_gnt, mem_rvalid, bus_err;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;

    cmd_t            iss_q[$];
    logic [XLEN-1:0] rd_q[$];
    cmd_t            exp_cmd;
    logic [XLEN-1:0] exp_rd;
    int              n_checks = 0;
    int              n_pass   = 0;

    imem_dmem_arbiter #(.XLEN(XLEN), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    // Advance to 1ns after the next rising edge and drive the memory-side inputs.
    task automatic step(input logic gnt, input logic rv, input logic [XLEN-1:0] rd);
        @(posedge clk);
        #1;
        mem_gnt    = gnt;
        mem_rvalid = rv;
        mem_rdata  = rd;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        step(1'b0, 1'b0, '0);
        rst = 1'b1;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        rst = 1'b0;
        iss_q.delete();
        rd_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 70'd0) $display("FAIL reset_mem_regs: got %h want 0", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}); else n_pass++;
        n_checks++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b want 0", bus_err); else n_pass++;
        n_checks++; if ({if_stall, d_stall} !== 2'b00) $display("FAIL reset_stalls_idle: got %b want 00", {if_stall, d_stall}); else n_pass++;
        if_req = 1'b1; d_req = 1'b1;
        #1;
        n_checks++; if ({if_stall, d_stall} !== 2'b11) $display("FAIL reset_stalls_req: got %b want 11", {if_stall, d_stall}); else n_pass++;
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_single_fetch();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h0;
        iss_q.push_back({1'b0, 4'h0, 32'h0, 32'h0});
        #1;
        n_checks++; if (if_stall !== 1'b1) $display("FAIL fetch_c0_stall: got %b want 1", if_stall); else n_pass++;
        step(1'b1, 1'b0, '0); #1;
        exp_cmd = iss_q.pop_front();
        n_checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, exp_cmd}) $display("FAIL fetch_issue: got %h want %h", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, exp_cmd}); else n_pass++;
        n_checks++; if (if_stall !== 1'b1) $display("FAIL fetch_c1_stall: got %b want 1", if_stall); else n_pass++;
        step(1'b0, 1'b1, 32'h0000_0013); rd_q.push_back(32'h0000_0013); #1;
        exp_rd = rd_q.pop_front();
        n_checks++; if (if_stall !== 1'b0) $display("FAIL fetch_c2_release: got %b want 0", if_stall); else n_pass++;
        n_checks++; if (if_rdata !== exp_rd) $display("FAIL fetch_rdata: got %h want %h", if_rdata, exp_rd); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL fetch_c2_mem_req: got %b want 0", mem_req); else n_pass++;
        step(1'b0, 1'b0, '0); if_req = 1'b0; #1;
        n_checks++; if ({mem_req, if_stall} !== 2'b00) $display("FAIL fetch_c3_idle: got %b want 00", {mem_req, if_stall}); else n_pass++;
    endtask

    task automatic test_round_robin();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        iss_q.push_back({1'b0, 4'h0, 32'h100, 32'h0});
        iss_q.push_back({1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF});
        iss_q.push_back({1'b0, 4'h0, 32'h104, 32'h0});
        #1;
        n_checks++; if ({if_stall, d_stall} !== 2'b11) $display("FAIL rr_c0_stalls: got %b want 11", {if_stall, d_stall}); else n_pass++;
        step(1'b1, 1'b0, '0); #1;
        exp_cmd = iss_q.pop_front();
        n_checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, exp_cmd}) $display("FAIL rr_first_fetch: got %h want %h", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, exp_cmd}); else n_pass++;
        step(1'b0, 1'b1, 32'h1111_1111); rd_q.push_back(32'h1111_1111); #1;
        exp_rd = rd_q.pop_front();
        n_checks++; if ({if_stall, d_stall, if_rdata} !== {2'b01, exp_rd}) $display("FAIL rr_fetch_release: got %h want %h", {if_stall, d_stall, if_rdata}, {2'b01, exp_rd}); else n_pass++;
        step(1'b0, 1'b0, '0); if_addr = 32'h104; #1;
        step(1'b1, 1'b0, '0); #1;
        exp_cmd = iss_q.pop_front();
        n_checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, exp_cmd}) $display("FAIL rr_store_issue: got %h want %h", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, exp_cmd}); else n_pass++;
        step(1'b0, 1'b1, '0); #1;
        n_checks++; if ({if_stall, d_stall} !== 2'b10) $display("FAIL rr_store_release: got %b want 10", {if_stall, d_stall}); else n_pass++;
        step(1'b0, 1'b0, '0); #1;
        step(1'b1, 1'b0, '0); #1;
        exp_cmd = iss_q.pop_front();
        n_checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, exp_cmd}) $display("FAIL rr_second_tie_fetch: got %h want %h", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, exp_cmd}); else n_pass++;
        step(1'b0, 1'b1, 32'h2222_2222); rd_q.push_back(32'h2222_2222); #1;
        exp_rd = rd_q.pop_front();
        n_checks++; if ({if_stall, d_stall, if_rdata} !== {2'b01, exp_rd}) $display("FAIL rr_second_fetch_release: got %h want %h", {if_stall, d_stall, if_rdata}, {2'b01, exp_rd}); else n_pass++;
        step(1'b0, 1'b0, '0); idle_inputs();
    endtask

    task automatic test_flush();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h40;
        iss_q.push_back({1'b0, 4'h0, 32'h40, 32'h0});
        step(1'b1, 1'b0, '0); #1;
        exp_cmd = iss_q.pop_front();
        n_checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, exp_cmd}) $display("FAIL flush_first_issue: got %h want %h", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, exp_cmd}); else n_pass++;
        step(1'b0, 1'b0, '0); if_flush = 1'b1; if_addr = 32'h80; #1;
        n_checks++; if (if_stall !== 1'b1) $display("FAIL flush_wait_stall: got %b want 1", if_stall); else n_pass++;
        step(1'b0, 1'b1, 32'h0000_0BAD); if_flush = 1'b0;
        iss_q.push_back({1'b0, 4'h0, 32'h80, 32'h0});
        #1;
        n_checks++; if (if_stall !== 1'b1) $display("FAIL flush_discard_stall: got %b want 1", if_stall); else n_pass++;
        step(1'b0, 1'b0, '0); #1;
        n_checks++; if ({mem_req, if_stall} !== 2'b01) $display("FAIL flush_idle: got %b want 01", {mem_req, if_stall}); else n_pass++;
        step(1'b1, 1'b0, '0); #1;
        exp_cmd = iss_q.pop_front();
        n_checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, exp_cmd}) $display("FAIL flush_refetch_addr: got %h want %h", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, exp_cmd}); else n_pass++;
        step(1'b0, 1'b1, 32'h0000_0093); rd_q.push_back(32'h0000_0093); #1;
        exp_rd = rd_q.pop_front();
        n_checks++; if ({if_stall, if_rdata} !== {1'b0, exp_rd}) $display("FAIL flush_refetch_release: got %h want %h", {if_stall, if_rdata}, {1'b0, exp_rd}); else n_pass++;
        step(1'b0, 1'b0, '0); idle_inputs();
    endtask

    task automatic test_gnt_hold();
        apply_reset();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200; d_wdata = '0;
        iss_q.push_back({1'b0, 4'hF, 32'h200, 32'h0});
        #1;
        n_checks++; if (d_stall !== 1'b1) $display("FAIL hold_c0_stall: got %b want 1", d_stall); else n_pass++;
        for (int c = 1; c <= 4; c++) begin
            // Stray rvalid in cycle 2 arrives while the request is still ungranted.
            step(c == 4, c == 2, 32'hFFFF_FFFF);
            d_addr = 32'h204;
            #1;
            n_checks++; if ({mem_req, mem_addr, d_stall} !== {1'b1, 32'h200, 1'b1}) $display("FAIL hold_c%0d: got %h want %h", c, {mem_req, mem_addr, d_stall}, {1'b1, 32'h200, 1'b1}); else n_pass++;
        end
        exp_cmd = iss_q.pop_front();
        n_checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, exp_cmd}) $display("FAIL hold_issue: got %h want %h", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, exp_cmd}); else n_pass++;
        step(1'b0, 1'b1, 32'hCAFE_F00D); rd_q.push_back(32'hCAFE_F00D); #1;
        exp_rd = rd_q.pop_front();
        n_checks++; if ({d_stall, d_rdata} !== {1'b0, exp_rd}) $display("FAIL hold_load_release: got %h want %h", {d_stall, d_rdata}, {1'b0, exp_rd}); else n_pass++;
        step(1'b0, 1'b0, '0); idle_inputs();
    endtask

    task automatic test_timeout();
        logic exp_err;
        apply_reset();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h300; d_wdata = 32'h55;
        iss_q.push_back({1'b1, 4'h3, 32'h300, 32'h55});
        step(1'b1, 1'b0, '0); #1;
        exp_cmd = iss_q.pop_front();
        n_checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, exp_cmd}) $display("FAIL timeout_issue: got %h want %h", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, exp_cmd}); else n_pass++;
        for (int c = 2; c <= 12; c++) begin
            step(1'b0, 1'b0, '0); #1;
            exp_err = (c >= 9);
            n_checks++; if ({bus_err, d_stall} !== {exp_err, 1'b1}) $display("FAIL timeout_c%0d: got %b want %b", c, {bus_err, d_stall}, {exp_err, 1'b1}); else n_pass++;
        end
        step(1'b0, 1'b0, '0); rst = 1'b1; d_req = 1'b0;
        step(1'b0, 1'b0, '0); #1;
        n_checks++; if ({bus_err, mem_req, d_stall} !== 3'b000) $display("FAIL timeout_rst_clear: got %b want 000", {bus_err, mem_req, d_stall}); else n_pass++;
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h500;
        iss_q.push_back({1'b0, 4'h0, 32'h500, 32'h0});
        step(1'b1, 1'b0, '0); #1;
        exp_cmd = iss_q.pop_front();
        n_checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, exp_cmd}) $display("FAIL timeout_after_rst_issue: got %h want %h", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, exp_cmd}); else n_pass++;
        step(1'b0, 1'b1, 32'h0000_0077); rd_q.push_back(32'h0000_0077); #1;
        exp_rd = rd_q.pop_front();
        n_checks++; if ({if_stall, bus_err, if_rdata} !== {2'b00, exp_rd}) $display("FAIL timeout_after_rst_release: got %h want %h", {if_stall, bus_err, if_rdata}, {2'b00, exp_rd}); else n_pass++;
        step(1'b0, 1'b0, '0); idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h400; d_wdata = '0;
        iss_q.push_back({1'b0, 4'hF, 32'h400, 32'h0});
        iss_q.push_back({1'b0, 4'hF, 32'h400, 32'h0});
        step(1'b1, 1'b0, '0); #1;
        exp_cmd = iss_q.pop_front();
        n_checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, exp_cmd}) $display("FAIL rstmid_issue: got %h want %h", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, exp_cmd}); else n_pass++;
        step(1'b0, 1'b0, '0); rst = 1'b1; #1;
        n_checks++; if (d_stall !== 1'b1) $display("FAIL rstmid_wait_stall: got %b want 1", d_stall); else n_pass++;
        step(1'b0, 1'b1, 32'hAAAA_5555); rst = 1'b0; #1;
        n_checks++; if ({d_stall, mem_req} !== 2'b10) $display("FAIL rstmid_stray_rvalid: got %b want 10", {d_stall, mem_req}); else n_pass++;
        step(1'b1, 1'b0, '0); #1;
        exp_cmd = iss_q.pop_front();
        n_checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, exp_cmd}) $display("FAIL rstmid_reissue: got %h want %h", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, exp_cmd}); else n_pass++;
        step(1'b0, 1'b1, 32'h1234_5678); rd_q.push_back(32'h1234_5678); #1;
        exp_rd = rd_q.pop_front();
        n_checks++; if ({d_stall, d_rdata} !== {1'b0, exp_rd}) $display("FAIL rstmid_release: got %h want %h", {d_stall, d_rdata}, {1'b0, exp_rd}); else n_pass++;
        step(1'b0, 1'b0, '0); idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_flush();
        test_gnt_hold();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
